mq_read_scheduler: RTL and testbench

//  Read-side scheduler for the multi-queue async FIFO, in the read (clk2) domain.

---
 rtl/mq_read_scheduler_pkg.sv | 24 ++
 rtl/mq_read_scheduler_rr_arb.sv | 31 +++
 rtl/mq_read_scheduler.sv | 105 ++++++++++
 tb/tb_mq_read_scheduler.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/mq_read_scheduler_pkg.sv
// Shared types, defaults and the one-hot decode helper for the multi-queue FIFO read side.
// Helpers are purely combinational.
package mq_read_scheduler_pkg;

    localparam int NR_OF_QUEUES_DEF = 16;
    localparam int A_HI_SIZE_DEF    = 4;
    localparam int DATA_WIDTH_DEF   = 36;
    localparam int EMPTY_LAT_DEF    = 3;
    localparam int HOLDOFF_W        = 3;
    localparam int MAX_Q            = 256;

    typedef logic [HOLDOFF_W-1:0] holdoff_t;

    // Callers left-align a narrower [0:N-1] vector so that bit 0 stays queue 0.
    function automatic logic [7:0] onehot2bin(input logic [0:MAX_Q-1] oh);
        logic [7:0] b;
        b = '0;
        for (int i = 0; i < MAX_Q; i++) begin
            if (oh[i]) b = b | 8'(i);
        end
        return b;
    endfunction

endpackage

// File: rtl/mq_read_scheduler_rr_arb.sv
// Round-robin arbiter: request vector plus search pointer -> one-hot grant and next pointer.
// Purely combinational; the pointer register lives in the parent.
module mq_read_scheduler_rr_arb #(
    parameter int N  = 16,
    parameter int AW = 4
) (
    input  logic [0:N-1]  i_req,
    input  logic [AW-1:0] i_ptr,
    output logic [0:N-1]  o_grant,
    output logic          o_gnt_vld,
    output logic [AW-1:0] o_next_ptr
);

    always_comb begin
        int idx;
        idx        = 0;
        o_grant    = '0;
        o_gnt_vld  = 1'b0;
        o_next_ptr = i_ptr;
        for (int k = 0; k < N; k++) begin
            idx = int'(i_ptr) + k;
            if (idx >= N) idx = idx - N;
            if (!o_gnt_vld && i_req[idx]) begin
                o_gnt_vld   = 1'b1;
                o_grant[idx] = 1'b1;
                o_next_ptr  = (idx == N - 1) ? '0 : AW'(idx + 1);
            end
        end
    end

endmodule

// File: rtl/mq_read_scheduler.sv
// Read-side scheduler: round-robin one-hot read strobe, RAM word captured a cycle later into a
// 2-entry skid buffer (2-cycle read-to-valid); stalls issuing once buffered + in-flight words reach 2.
module mq_read_scheduler
    import mq_read_scheduler_pkg::*;
#(
    parameter int nr_of_queues = NR_OF_QUEUES_DEF,
    parameter int a_hi_size    = A_HI_SIZE_DEF,
    parameter int data_width   = DATA_WIDTH_DEF,
    parameter int empty_lat    = EMPTY_LAT_DEF
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [0:nr_of_queues-1] fifo_empty,
    output logic [0:nr_of_queues-1] read,
    input  logic [data_width-1:0]   q_in,
    output logic [data_width-1:0]   dout,
    output logic [a_hi_size-1:0]    dout_qid,
    output logic                    dout_valid,
    input  logic                    dout_ready
);

    logic [a_hi_size-1:0]  r_ptr;
    holdoff_t              r_holdoff [nr_of_queues];
    logic                  r_inflight;
    logic [a_hi_size-1:0]  r_inflight_qid;
    logic [data_width-1:0] r_buf_dat [2];
    logic [a_hi_size-1:0]  r_buf_qid [2];
    logic                  r_wr_sel;
    logic                  r_rd_sel;
    logic [1:0]            r_occ;

    logic [0:nr_of_queues-1] w_req;
    logic [0:nr_of_queues-1] w_grant;
    logic                    w_gnt_vld;
    logic [a_hi_size-1:0]    w_next_ptr;
    logic [a_hi_size-1:0]    w_grant_qid;
    logic                    w_pop;
    logic                    w_issue;

    always_comb begin
        w_req = '0;
        for (int i = 0; i < nr_of_queues; i++) begin
            w_req[i] = !fifo_empty[i] && (r_holdoff[i] == '0);
        end
    end

    mq_read_scheduler_rr_arb #(
        .N  (nr_of_queues),
        .AW (a_hi_size)
    ) u_arb (
        .i_req      (w_req),
        .i_ptr      (r_ptr),
        .o_grant    (w_grant),
        .o_gnt_vld  (w_gnt_vld),
        .o_next_ptr (w_next_ptr)
    );

    assign w_grant_qid = a_hi_size'(onehot2bin({w_grant, {(MAX_Q - nr_of_queues){1'b0}}}));
    assign dout_valid  = (r_occ != 2'd0);
    assign dout        = r_buf_dat[r_rd_sel];
    assign dout_qid    = r_buf_qid[r_rd_sel];
    assign w_pop       = dout_valid && dout_ready;

    // A word leaving the buffer this cycle frees its slot, which keeps one word per cycle
    // flowing when the consumer is always ready.
    assign w_issue = rst && w_gnt_vld &&
                     (({1'b0, r_occ} + 3'(r_inflight) - 3'(w_pop)) < 3'd2);
    assign read    = w_issue ? w_grant : '0;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_ptr          <= '0;
            r_inflight     <= 1'b0;
            r_inflight_qid <= '0;
            r_wr_sel       <= 1'b0;
            r_rd_sel       <= 1'b0;
            r_occ          <= 2'd0;
            for (int i = 0; i < nr_of_queues; i++) r_holdoff[i] <= '0;
            for (int e = 0; e < 2; e++) begin
                r_buf_dat[e] <= '0;
                r_buf_qid[e] <= '0;
            end
        end else begin
            for (int i = 0; i < nr_of_queues; i++) begin
                if (w_issue && w_grant[i])
                    r_holdoff[i] <= holdoff_t'(empty_lat);
                else if (r_holdoff[i] != '0)
                    r_holdoff[i] <= r_holdoff[i] - holdoff_t'(1);
            end
            if (w_issue) begin
                r_ptr          <= w_next_ptr;
                r_inflight_qid <= w_grant_qid;
            end
            r_inflight <= w_issue;
            if (r_inflight) begin
                r_buf_dat[r_wr_sel] <= q_in;
                r_buf_qid[r_wr_sel] <= r_inflight_qid;
                r_wr_sel            <= ~r_wr_sel;
            end
            if (w_pop) r_rd_sel <= ~r_rd_sel;
            r_occ <= r_occ + 2'(r_inflight) - 2'(w_pop);
        end
    end

endmodule

// File: tb/tb_mq_read_scheduler.sv
// Directed bench for mq_read_scheduler: reset, round-robin, holdoff, backpressure,
// throughput, mid-flight reset and a randomised scoreboard phase.
module tb_mq_read_scheduler;

    localparam int NQ  = 16;
    localparam int AW  = 4;
    localparam int DW  = 36;
    localparam int LAT = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic [0:NQ-1] fifo_empty;
    logic [0:NQ-1] read;
    logic [DW-1:0] q_in;
    logic [DW-1:0] dout;
    logic [AW-1:0] dout_qid;
    logic          dout_valid;
    logic          dout_ready;

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;

    logic [0:NQ-1]      exp4 [6] = '{16'h8000, 16'h4000, 16'h0000, 16'h0000, 16'h0000, 16'h0000};
    int                 exp_rr [6] = '{2, 5, 9, 2, 5, 9};
    logic [AW+DW-1:0]   mq [$];
    int                 mh [NQ];
    logic               pend;
    int                 pend_q;

    always #5 clk = ~clk;

    mq_read_scheduler #(
        .nr_of_queues (NQ),
        .a_hi_size    (AW),
        .data_width   (DW),
        .empty_lat    (LAT)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .fifo_empty (fifo_empty),
        .read       (read),
        .q_in       (q_in),
        .dout       (dout),
        .dout_qid   (dout_qid),
        .dout_valid (dout_valid),
        .dout_ready (dout_ready)
    );

    function automatic logic [DW-1:0] mk(input int c);
        return {4'h5, 32'(c)};
    endfunction

    function automatic int dec(input logic [0:NQ-1] v);
        int r;
        r = -1;
        for (int i = 0; i < NQ; i++) if (v[i]) r = i;
        return r;
    endfunction

    function automatic logic [0:NQ-1] only(input int a, input int b, input int c);
        logic [0:NQ-1] v;
        v = '1;
        if (a >= 0) v[a] = 1'b0;
        if (b >= 0) v[b] = 1'b0;
        if (c >= 0) v[c] = 1'b0;
        return v;
    endfunction

    task automatic step();
        @(posedge clk);
        cyc++;
        @(negedge clk);
        q_in = mk(cyc);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One scoreboard cycle, sampled mid-cycle while inputs are stable.
    task automatic sb_sample();
        int g;
        chk("sb_onehot", 64'($countones(read) <= 1), 64'd1);
        if (dout_valid && dout_ready) begin
            if (mq.size() == 0) chk("sb_spurious", {63'd0, dout_valid}, 64'd0);
            else                chk("sb_word", 64'({dout_qid, dout}), 64'(mq.pop_front()));
        end
        if (pend) mq.push_back({AW'(pend_q), q_in});
        g = ($countones(read) == 1) ? dec(read) : -1;
        if (g >= 0) begin
            chk("sb_not_empty", {63'd0, fifo_empty[g]}, 64'd0);
            chk("sb_holdoff", 64'(mh[g]), 64'd0);
        end
        for (int j = 0; j < NQ; j++) if (mh[j] != 0) mh[j]--;
        if (g >= 0) mh[g] = LAT;
        pend   = (g >= 0);
        pend_q = g;
    endtask

    initial begin
        int c0, s, nrd, nvld;
        int gq[$], gc[$], tq[$], tc[$];
        logic [DW-1:0] td[$];

        // Reset with every queue non-empty.
        rst = 1'b0; fifo_empty = '0; dout_ready = 1'b1; q_in = mk(0);
        pend = 1'b0; pend_q = 0;
        for (int j = 0; j < NQ; j++) mh[j] = 0;
        repeat (3) step();
        chk("rst_read", 64'(read), 64'd0);
        chk("rst_valid", {63'd0, dout_valid}, 64'd0);
        chk("rst_dout", 64'(dout), 64'd0);
        chk("rst_qid", 64'(dout_qid), 64'd0);
        rst = 1'b1; #1;
        chk("first_read", 64'(read), 64'h8000);

        // Backpressure: two words accumulate, then issue stops with a stable head.
        dout_ready = 1'b0; #1;
        c0 = cyc;
        for (int i = 0; i < 6; i++) begin
            chk("bp_read", 64'(read), 64'(exp4[i]));
            if (i >= 2) begin
                chk("bp_valid", {63'd0, dout_valid}, 64'd1);
                chk("bp_dout", 64'(dout), 64'(mk(c0 + 1)));
                chk("bp_qid", 64'(dout_qid), 64'd0);
            end
            step();
        end
        fifo_empty = '1; dout_ready = 1'b1; #1;
        chk("drain0_qid", 64'(dout_qid), 64'd0);
        chk("drain0_dout", 64'(dout), 64'(mk(c0 + 1)));
        step();
        chk("drain1_valid", {63'd0, dout_valid}, 64'd1);
        chk("drain1_qid", 64'(dout_qid), 64'd1);
        chk("drain1_dout", 64'(dout), 64'(mk(c0 + 2)));
        step();
        chk("drain_empty", {63'd0, dout_valid}, 64'd0);

        // Round-robin over queues 2, 5, 9.
        fifo_empty = only(2, 5, 9); #1;
        for (int i = 0; i < 30; i++) begin
            chk("rr_onehot", 64'($countones(read) <= 1), 64'd1);
            if (read != '0) begin gq.push_back(dec(read)); gc.push_back(cyc); end
            if (dout_valid && dout_ready) begin
                tq.push_back(int'(dout_qid)); tc.push_back(cyc); td.push_back(dout);
            end
            step();
        end
        chk("rr_count", 64'(gq.size() >= 6 && tq.size() >= 6), 64'd1);
        if (gq.size() >= 6 && tq.size() >= 6) begin
            for (int k = 0; k < 6; k++) begin
                chk("rr_order", 64'(gq[k]), 64'(exp_rr[k]));
                chk("rr_out_qid", 64'(tq[k]), 64'(gq[k]));
                chk("rr_out_lat", 64'(tc[k] - gc[k]), 64'd2);
                chk("rr_out_dat", 64'(td[k]), 64'(mk(gc[k] + 1)));
            end
        end

        // Holdoff: a lone queue is read every LAT+1 cycles.
        fifo_empty = only(7, -1, -1); #1;
        gq.delete(); gc.delete();
        for (int i = 0; i < 20; i++) begin
            if (read != '0) begin gq.push_back(dec(read)); gc.push_back(cyc); end
            step();
        end
        chk("ho_count", 64'(gq.size()), 64'd5);
        for (int k = 0; k < gq.size(); k++) begin
            chk("ho_queue", 64'(gq[k]), 64'd7);
            if (k > 0) chk("ho_gap", 64'(gc[k] - gc[k-1]), 64'(LAT + 1));
        end

        // Full throughput with every queue available.
        fifo_empty = '0; #1;
        nrd = 0; nvld = 0;
        for (int i = 0; i < 20; i++) begin
            if (read != '0) nrd++;
            if (i >= 2 && dout_valid) nvld++;
            step();
        end
        chk("tp_reads", 64'(nrd), 64'd20);
        chk("tp_valid", 64'(nvld), 64'd18);

        // Reset the cycle after a strobe.
        chk("mid_strobe", 64'(read != '0), 64'd1);
        step();
        rst = 1'b0; #1;
        chk("mid_read_off", 64'(read), 64'd0);
        step();
        chk("mid_valid", {63'd0, dout_valid}, 64'd0);
        rst = 1'b1; #1;
        chk("mid_ptr0", 64'(read), 64'h8000);
        fifo_empty = '1; #1;
        step();
        chk("mid_no_word1", {63'd0, dout_valid}, 64'd0);
        step();
        chk("mid_no_word2", {63'd0, dout_valid}, 64'd0);

        // Random scoreboard, then drain.
        for (int i = 0; i < 10000; i++) begin
            fifo_empty = NQ'($urandom);
            dout_ready = ($urandom_range(0, 3) != 0);
            #1;
            sb_sample();
            step();
        end
        fifo_empty = '1; dout_ready = 1'b1; #1;
        for (int i = 0; i < 6; i++) begin
            sb_sample();
            step();
        end
        chk("sb_all_delivered", 64'(mq.size()), 64'd0);
        chk("sb_final_valid", {63'd0, dout_valid}, 64'd0);
        s = n_err;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, s);
        $finish;
    end

endmodule
